// File: rtl/adxl_pkg.sv
// Shared defaults and state encoding for the accelerometer ring-buffer writer.
package adxl_pkg;

  localparam int unsigned ADDR_BITS_DEF = 10;
  localparam int unsigned CNT_BITS_DEF  = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/adxl_bufwr.sv
// Writes accelerometer bytes into a BRAM ring and commits whole xyz frames.
// A write pointer publishes only complete frames; a partial frame is dropped on overflow.
module adxl_bufwr
  import adxl_pkg::*;
#(
  parameter int unsigned ADDR_BITS = ADDR_BITS_DEF,
  parameter int unsigned CNT_BITS  = CNT_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [7:0]           wrdata,
  input  logic                 wr,
  input  logic                 wr16,
  input  logic                 x,
  input  logic                 mode16,
  input  logic                 clr,
  input  logic [ADDR_BITS-1:0] rd_ptr,
  output logic [ADDR_BITS-1:0] bram_addr,
  output logic [7:0]           bram_wdata,
  output logic                 bram_we,
  output logic [ADDR_BITS-1:0] wr_ptr,
  output logic [CNT_BITS-1:0]  frame_cnt,
  output logic                 overflow,
  output logic                 locked
);

  state_t               state, state_nxt;
  logic                 mode16_l, mode16_l_nxt;
  logic [ADDR_BITS-1:0] waddr, waddr_nxt;
  logic [ADDR_BITS-1:0] wr_ptr_nxt;
  logic [CNT_BITS-1:0]  frame_cnt_nxt;
  logic                 overflow_nxt;
  logic                 bram_we_nxt;
  logic [ADDR_BITS-1:0] bram_addr_nxt;
  logic [7:0]           bram_wdata_nxt;

  logic                 sel16_c;
  logic                 strobe_c;
  logic [ADDR_BITS-1:0] waddr_inc_c;
  logic                 full_c;

  // The byte-mode selection is frozen for the life of a RUN session.
  assign sel16_c     = (state == ST_RUN) ? mode16_l : mode16;
  assign strobe_c    = sel16_c ? wr16 : wr;
  assign waddr_inc_c = waddr + ADDR_BITS'(1);
  assign full_c      = (waddr_inc_c == rd_ptr);

  always_comb begin
    state_nxt      = state;
    mode16_l_nxt   = mode16_l;
    waddr_nxt      = waddr;
    wr_ptr_nxt     = wr_ptr;
    frame_cnt_nxt  = frame_cnt;
    overflow_nxt   = overflow;
    bram_we_nxt    = 1'b0;
    bram_addr_nxt  = bram_addr;
    bram_wdata_nxt = bram_wdata;

    if (clr) begin
      state_nxt     = ST_IDLE;
      waddr_nxt     = '0;
      wr_ptr_nxt    = '0;
      frame_cnt_nxt = '0;
      overflow_nxt  = 1'b0;
    end else if (strobe_c) begin
      if (state == ST_IDLE) begin
        // In IDLE waddr always equals wr_ptr, so the frame starts at wr_ptr.
        if (x) begin
          if (full_c) begin
            overflow_nxt = 1'b1;
          end else begin
            state_nxt      = ST_RUN;
            mode16_l_nxt   = mode16;
            bram_we_nxt    = 1'b1;
            bram_addr_nxt  = wr_ptr;
            bram_wdata_nxt = wrdata;
            waddr_nxt      = wr_ptr + ADDR_BITS'(1);
          end
        end
      end else begin
        if (full_c) begin
          overflow_nxt = 1'b1;
          waddr_nxt    = wr_ptr;
          state_nxt    = ST_IDLE;
        end else begin
          if (x) begin
            wr_ptr_nxt    = waddr;
            frame_cnt_nxt = frame_cnt + CNT_BITS'(1);
          end
          bram_we_nxt    = 1'b1;
          bram_addr_nxt  = waddr;
          bram_wdata_nxt = wrdata;
          waddr_nxt      = waddr_inc_c;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= ST_IDLE;
      mode16_l   <= 1'b0;
      waddr      <= '0;
      wr_ptr     <= '0;
      frame_cnt  <= '0;
      overflow   <= 1'b0;
      bram_we    <= 1'b0;
      bram_addr  <= '0;
      bram_wdata <= '0;
      locked     <= 1'b0;
    end else begin
      state      <= state_nxt;
      mode16_l   <= mode16_l_nxt;
      waddr      <= waddr_nxt;
      wr_ptr     <= wr_ptr_nxt;
      frame_cnt  <= frame_cnt_nxt;
      overflow   <= overflow_nxt;
      bram_we    <= bram_we_nxt;
      bram_addr  <= bram_addr_nxt;
      bram_wdata <= bram_wdata_nxt;
      locked     <= (state_nxt == ST_RUN);
    end
  end

endmodule

// File: tb/tb_adxl_bufwr.sv
// Self-checking bench for adxl_bufwr on a 16-byte ring.
module tb_adxl_bufwr;

  localparam int unsigned AB   = 4;
  localparam int unsigned CB   = 16;
  localparam int          RING = 16;

  logic          clk = 1'b0;
  logic          rstn;
  logic [7:0]    wrdata;
  logic          wr, wr16, x, mode16, clr;
  logic [AB-1:0] rd_ptr;
  logic [AB-1:0] bram_addr;
  logic [7:0]    bram_wdata;
  logic          bram_we;
  logic [AB-1:0] wr_ptr;
  logic [CB-1:0] frame_cnt;
  logic          overflow;
  logic          locked;

  adxl_bufwr #(.ADDR_BITS(AB), .CNT_BITS(CB)) dut (
    .clk(clk), .rstn(rstn), .wrdata(wrdata), .wr(wr), .wr16(wr16), .x(x),
    .mode16(mode16), .clr(clr), .rd_ptr(rd_ptr), .bram_addr(bram_addr),
    .bram_wdata(bram_wdata), .bram_we(bram_we), .wr_ptr(wr_ptr),
    .frame_cnt(frame_cnt), .overflow(overflow), .locked(locked)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int n_we  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: ring occupancy arithmetic on plain integers.
  bit m_run, m_mode, m_ovf, e_we;
  int m_waddr, m_wrptr, m_cnt, e_addr, e_data;

  task automatic model_reset();
    m_run = 0; m_mode = 0; m_ovf = 0; e_we = 0;
    m_waddr = 0; m_wrptr = 0; m_cnt = 0; e_addr = 0; e_data = 0;
  endtask

  task automatic model_step();
    bit use16, s, full;
    int used;
    use16 = m_run ? m_mode : mode16;
    s     = use16 ? wr16 : wr;
    used  = (m_waddr - int'(rd_ptr) + RING) % RING;
    full  = (used == RING - 1);
    e_we  = 0;
    if (clr) begin
      m_run = 0; m_waddr = 0; m_wrptr = 0; m_cnt = 0; m_ovf = 0;
    end else if (s && (m_run || x)) begin
      if (full) begin
        m_ovf = 1;
        if (m_run) begin m_waddr = m_wrptr; m_run = 0; end
      end else begin
        if (!m_run) begin
          m_run = 1; m_mode = mode16;
        end else if (x) begin
          m_wrptr = m_waddr; m_cnt = (m_cnt + 1) % 65536;
        end
        e_we = 1; e_addr = m_waddr; e_data = int'(wrdata);
        m_waddr = (m_waddr + 1) % RING;
      end
    end
  endtask

  task automatic compare_model(input string tag);
    chk({tag, ".we"}, 32'(bram_we), 32'(e_we));
    if (e_we) begin
      chk({tag, ".addr"}, 32'(bram_addr), 32'(e_addr));
      chk({tag, ".data"}, 32'(bram_wdata), 32'(e_data));
    end
    chk({tag, ".wr_ptr"}, 32'(wr_ptr), 32'(m_wrptr));
    chk({tag, ".frame_cnt"}, 32'(frame_cnt), 32'(m_cnt));
    chk({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
    chk({tag, ".locked"}, 32'(locked), 32'(m_run));
  endtask

  task automatic cyc(input logic w, input logic w16, input logic xx, input logic m16,
                     input logic c, input logic [7:0] d, input string tag);
    wr = w; wr16 = w16; x = xx; mode16 = m16; clr = c; wrdata = d;
    @(posedge clk);
    model_step();
    #1;
    if (bram_we) n_we++;
    compare_model(tag);
  endtask

  task automatic do_reset();
    #1;
    rstn = 1'b0;
    wr = 0; wr16 = 0; x = 0; mode16 = 0; clr = 0; wrdata = 8'h00;
    model_reset();
    #12;
    rstn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic          wr, wr16, x, mode16, clr;
    logic [7:0]    d;
    logic [AB-1:0] rp;
    logic          we;
    logic [AB-1:0] addr;
    logic [7:0]    wd;
    logic [AB-1:0] wp;
    logic [CB-1:0] cnt;
    logic          ovf, lk;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic w, logic w16, logic xx, logic m16, logic d_clr,
                              logic [7:0] d, logic we_e, logic [AB-1:0] a, logic [AB-1:0] wp,
                              logic [CB-1:0] cnt, logic lk);
    vec_t v;
    v.wr = w; v.wr16 = w16; v.x = xx; v.mode16 = m16; v.clr = d_clr; v.d = d;
    v.rp = '0; v.we = we_e; v.addr = a; v.wd = d; v.wp = wp; v.cnt = cnt;
    v.ovf = 1'b0; v.lk = lk;
    return v;
  endfunction

  initial begin
    rstn = 1'b0;
    rd_ptr = '0;
    wr = 0; wr16 = 0; x = 0; mode16 = 0; clr = 0; wrdata = 8'h00;
    model_reset();

    // Reset values while rstn is held low
    #12;
    chk("rst.we", 32'(bram_we), 0);
    chk("rst.addr", 32'(bram_addr), 0);
    chk("rst.wdata", 32'(bram_wdata), 0);
    chk("rst.wr_ptr", 32'(wr_ptr), 0);
    chk("rst.frame_cnt", 32'(frame_cnt), 0);
    chk("rst.overflow", 32'(overflow), 0);
    chk("rst.locked", 32'(locked), 0);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // Directed table: bytes before x, 9-byte frame, second frame start
    vt.push_back(mk(1, 0, 0, 0, 0, 8'hAA, 0, 4'd0, 4'd0, 16'd0, 0));
    vt.push_back(mk(1, 0, 0, 0, 0, 8'hAB, 0, 4'd0, 4'd0, 16'd0, 0));
    for (int i = 0; i < 9; i++)
      vt.push_back(mk(1, 0, (i == 0), 0, 0, 8'(8'h10 + i), 1, 4'(i), 4'd0, 16'd0, 1));
    vt.push_back(mk(1, 0, 1, 0, 0, 8'h20, 1, 4'd9, 4'd9, 16'd1, 1));
    vt.push_back(mk(0, 0, 1, 0, 0, 8'h30, 0, 4'd9, 4'd9, 16'd1, 1));
    vt.push_back(mk(0, 1, 0, 0, 0, 8'h55, 0, 4'd9, 4'd9, 16'd1, 1));
    vt.push_back(mk(1, 0, 0, 0, 0, 8'h21, 1, 4'd10, 4'd9, 16'd1, 1));

    foreach (vt[i]) begin
      wr = vt[i].wr; wr16 = vt[i].wr16; x = vt[i].x; mode16 = vt[i].mode16;
      clr = vt[i].clr; wrdata = vt[i].d; rd_ptr = vt[i].rp;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d.we", i), 32'(bram_we), 32'(vt[i].we));
      if (vt[i].we) begin
        chk($sformatf("vec%0d.addr", i), 32'(bram_addr), 32'(vt[i].addr));
        chk($sformatf("vec%0d.data", i), 32'(bram_wdata), 32'(vt[i].wd));
      end
      chk($sformatf("vec%0d.wr_ptr", i), 32'(wr_ptr), 32'(vt[i].wp));
      chk($sformatf("vec%0d.frame_cnt", i), 32'(frame_cnt), 32'(vt[i].cnt));
      chk($sformatf("vec%0d.overflow", i), 32'(overflow), 32'(vt[i].ovf));
      chk($sformatf("vec%0d.locked", i), 32'(locked), 32'(vt[i].lk));
    end

    // Overflow: 6-byte frames into a 16-byte ring with the reader parked at 0
    do_reset();
    rd_ptr = '0;
    for (int f = 0; f < 3; f++)
      for (int b = 0; b < 6; b++)
        cyc(1, 0, (b == 0), 0, 0, 8'(f * 16 + b), "ovf");
    chk("ovf.overflow", 32'(overflow), 1);
    chk("ovf.wr_ptr", 32'(wr_ptr), 12);
    chk("ovf.frame_cnt", 32'(frame_cnt), 2);
    chk("ovf.locked", 32'(locked), 0);
    rd_ptr = 4'd13;
    cyc(1, 0, 1, 0, 0, 8'h66, "ovf_idle_full");
    chk("ovf_idle_full.we", 32'(bram_we), 0);
    chk("ovf_idle_full.locked", 32'(locked), 0);
    rd_ptr = 4'd12;
    cyc(1, 0, 1, 0, 0, 8'h77, "ovf_resume");
    chk("ovf_resume.we", 32'(bram_we), 1);
    chk("ovf_resume.addr", 32'(bram_addr), 12);
    chk("ovf_resume.data", 32'(bram_wdata), 32'h77);
    chk("ovf_resume.locked", 32'(locked), 1);

    // 16-bit mode: only wr16 strobes count, then clr beats a coincident strobe
    do_reset();
    rd_ptr = '0;
    n_we = 0;
    for (int i = 0; i < 9; i++)
      cyc(1, ((i % 3) != 2), (i == 0), 1, 0, 8'(8'h40 + i), "m16");
    chk("m16.writes", 32'(n_we), 6);
    cyc(1, 1, 1, 0, 0, 8'h50, "m16_commit");
    chk("m16_commit.frame_cnt", 32'(frame_cnt), 1);
    chk("m16_commit.wr_ptr", 32'(wr_ptr), 6);
    cyc(1, 1, 1, 1, 1, 8'h51, "clr");
    chk("clr.we", 32'(bram_we), 0);
    chk("clr.wr_ptr", 32'(wr_ptr), 0);
    chk("clr.frame_cnt", 32'(frame_cnt), 0);
    chk("clr.locked", 32'(locked), 0);

    // Reset mid-frame drops the partial frame; next x byte goes to address 0
    do_reset();
    cyc(1, 0, 1, 0, 0, 8'h90, "mid");
    cyc(1, 0, 0, 0, 0, 8'h91, "mid");
    cyc(1, 0, 0, 0, 0, 8'h92, "mid");
    do_reset();
    chk("mid_rst.locked", 32'(locked), 0);
    cyc(1, 0, 0, 0, 0, 8'h93, "mid_rst");
    cyc(1, 0, 1, 0, 0, 8'h94, "mid_rst");
    chk("mid_rst.addr", 32'(bram_addr), 0);
    chk("mid_rst.data", 32'(bram_wdata), 32'h94);

    // Randomized traffic against the reference model
    do_reset();
    begin
      logic m16 = 1'b0;
      for (int n = 0; n < 3000; n++) begin
        if ($urandom_range(0, 63) == 0) m16 = ~m16;
        if ($urandom_range(0, 7) == 0) rd_ptr = AB'(m_wrptr);
        cyc(($urandom_range(0, 1) == 1), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 5) == 0), m16, ($urandom_range(0, 199) == 0),
            8'($urandom), "rand");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/adxl_bufwr.md
ADXL_BUFWR -- requirements
Module: adxl_bufwr

Interface
REQ-001 Parameter ADDR_BITS, 10, BRAM byte address width; ring size 2**ADDR_BITS bytes.
REQ-002 Parameter CNT_BITS, 16, frame counter width.
REQ-003 clk  in  1  single system clock; all logic on rising edge.
REQ-004 rstn  in  1  asynchronous active-low reset.
REQ-005 wrdata  in  8  byte from the SPI reader stage.
REQ-006 wr  in  1  1-clk strobe, every accel byte.
REQ-007 wr16  in  1  1-clk strobe, 16-bit mode bytes (3rd byte skipped).
REQ-008 x  in  1  high with first strobe of an xyz frame.
REQ-009 mode16  in  1  0:use wr, 1:use wr16.
REQ-010 clr  in  1  1-clk synchronous clear from ESP32 control.
REQ-011 rd_ptr  in  ADDR_BITS  host read pointer (next byte host will read).
REQ-012 bram_addr  out  ADDR_BITS  BRAM write address.
REQ-013 bram_wdata  out  8  BRAM write data.
REQ-014 bram_we  out  1  BRAM write enable, 1-clk.
REQ-015 wr_ptr  out  ADDR_BITS  committed pointer: all bytes before it belong to complete frames.
REQ-016 frame_cnt  out  CNT_BITS  count of committed frames, wraps.
REQ-017 overflow  out  1  sticky, set on dropped data.
REQ-018 locked  out  1  1 when state RUN.

Function
REQ-019 Strobe s = mode16_l ? wr16 : wr, where mode16_l is mode16 latched when entering RUN; in IDLE s uses live mode16.
REQ-020 States: IDLE (discard bytes), RUN (store bytes).
REQ-021 IDLE -> RUN on s with x=1; that byte is stored at address wr_ptr.
REQ-022 In RUN, each s stores wrdata at internal write address waddr, then waddr <= waddr+1 mod 2**ADDR_BITS.
REQ-023 Write latency: bram_addr/bram_wdata/bram_we registered, bram_we high exactly 1 cycle after s.
REQ-024 In RUN, s with x=1: wr_ptr <= waddr (before the store), frame_cnt <= frame_cnt+1, byte stored.
REQ-025 Full: waddr+1 == rd_ptr (mod ring); ring holds at most 2**ADDR_BITS-1 bytes; empty is rd_ptr == wr_ptr.
REQ-026 s while full: byte not written, overflow <= 1, waddr <= wr_ptr (partial frame discarded), state -> IDLE.
REQ-027 s with x=1 while full in IDLE: stay IDLE, overflow <= 1, no write.
REQ-028 clr: waddr, wr_ptr, frame_cnt <= 0, overflow <= 0, state -> IDLE, bram_we <= 0; clr has priority over a coincident s.
REQ-029 wr and wr16 asserted with mode16 mismatch: only selected strobe counts; non-selected ignored.
REQ-030 x without s: ignored.
REQ-031 rd_ptr is treated as synchronous to clk; no CDC inside block.

Reset
REQ-032 On rstn low: state IDLE, waddr=0, wr_ptr=0, frame_cnt=0, overflow=0, bram_we=0, bram_addr=0, bram_wdata=0, locked=0, mode16_l=0.
REQ-033 Reset mid-frame discards the partial frame; first stored byte after reset is next x byte at address 0.

Structure
REQ-034 Package adxl_pkg holds ADDR_BITS and CNT_BITS defaults and the state encoding (IDLE, RUN).
REQ-035 No sub-module; BRAM instantiated externally by top level.

Verification
REQ-036 Reset, then 9 bytes 0x10..0x18 with wr, x on first, mode16=0 -> bram_we 9 times, addresses 0..8, data 0x10..0x18; locked=1.
REQ-037 Second frame start (x) after 9 bytes -> wr_ptr=9, frame_cnt=1, byte at address 9.
REQ-038 Bytes with wr before any x -> no bram_we, locked=0; first x byte written at address 0.
REQ-039 ADDR_BITS=4, rd_ptr=0, continuous 6-byte frames -> byte that would land at 15 dropped, overflow=1, waddr rewound to wr_ptr=12, IDLE; after rd_ptr moves to 12 next x byte written at 12.
REQ-040 mode16=1 with wr on 9 bytes and wr16 on 6 of them -> exactly 6 writes; clr coincident with s -> no write, all counters 0, overflow 0.
